mac_operand_feeder: RTL

Upstream stage of the a*b+c MAC sequencer. Buffers whole operand triples (a, b, c) arriving on a valid/ready handshake and replays each one as three consecutive single-word beats with a valid strobe. A mandatory idle cycle separates triples so the downstream three-beat state machine re-synchronises. Its output pair drives the MAC stage's `validi` and `data_in` directly.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_triple_fifo.sv | 51 +++++
 rtl/mac_operand_feeder.sv | 114 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types for the MAC operand feeder: operand width, feeder FSM states and the
// buffered operand triple.
package mac_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    BEAT_A,
    BEAT_B,
    BEAT_C,
    GAP
  } feeder_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
  } mac_triple_t;

endpackage

// File: rtl/mac_triple_fifo.sv
// Synchronous FIFO of operand triples with registered occupancy count and full/empty flags.
module mac_triple_fifo
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  mac_triple_t wdata,
  input  logic        pop,
  output mac_triple_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  mac_triple_t     mem_q [DEPTH];
  logic            push_en, pop_en;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers a*b+c operand triples and replays each as three registered beats plus one idle cycle.
// Optional triple counter enabled by defining MAC_FEEDER_STATS_EN.
module mac_operand_feeder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = mac_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic [WORD_W-1:0] in_c,
  output logic              validi,
  output logic [WORD_W-1:0] data_in
`ifdef MAC_FEEDER_STATS_EN
  ,
  output logic [15:0]       triple_cnt
`endif
);

  import mac_pkg::*;

  feeder_state_t     state_q, state_d;
  mac_triple_t       push_data, head;
  logic              full, empty, push, pop;
  logic              rdy_en_q;
  logic              validi_d;
  logic [WORD_W-1:0] data_d;
  logic [WORD_W-1:0] hold_b_q, hold_b_d, hold_c_q, hold_c_d;

  // Ready is held low through reset and rises on the first edge after release.
  assign in_ready  = rdy_en_q && !full;
  assign push      = in_valid && in_ready;
  assign push_data = '{a: in_a, b: in_b, c: in_c};

  mac_triple_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(push_data),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_d  = state_q;
    validi_d = 1'b0;
    data_d   = '0;
    pop      = 1'b0;
    hold_b_d = hold_b_q;
    hold_c_d = hold_c_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (!empty) begin
          pop      = 1'b1;
          validi_d = 1'b1;
          data_d   = head.a;
          hold_b_d = head.b;
          hold_c_d = head.c;
          state_d  = BEAT_A;
        end else begin
          state_d  = IDLE;
        end
      end
      BEAT_A: begin
        validi_d = 1'b1;
        data_d   = hold_b_q;
        state_d  = BEAT_B;
      end
      BEAT_B: begin
        validi_d = 1'b1;
        data_d   = hold_c_q;
        state_d  = BEAT_C;
      end
      BEAT_C:  state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_en_q <= 1'b0;
      validi   <= 1'b0;
      data_in  <= '0;
      hold_b_q <= '0;
      hold_c_q <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      validi   <= validi_d;
      data_in  <= data_d;
      hold_b_q <= hold_b_d;
      hold_c_q <= hold_c_d;
    end
  end

`ifdef MAC_FEEDER_STATS_EN
  // Counts on the BEAT_B -> BEAT_C step, i.e. as c is issued; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      triple_cnt <= '0;
    end else if (state_q == BEAT_B) begin
      triple_cnt <= triple_cnt + 16'd1;
    end
  end
`endif

endmodule
